comb_stack_engine: RTL and testbench

COMB_STACK_ENGINE -- requirements
Module: comb_stack_engine

---
 rtl/comb_pkg.sv | 25 ++
 rtl/comb_pair_stack.sv | 61 ++++++
 rtl/comb_stack_engine.sv | 178 +++++++++++++++++
 tb/tb_comb_stack_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comb_pkg.sv
// Shared types for the combination engine: FSM state encoding, error codes, stack entry.
package comb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_POP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_STK   = 2'b10;
    localparam logic [1:0] ERR_SAT   = 2'b11;

    localparam int unsigned PAIR_N_W = 6;

    // Layout of one saved {n,m} pair at the default operand width; the stack
    // itself stores the same packing as a flat 2*N_W vector, n in the upper half.
    typedef struct packed {
        logic [PAIR_N_W-1:0] n;
        logic [PAIR_N_W-1:0] m;
    } pair_t;

endpackage

// File: rtl/comb_pair_stack.sv
// LIFO of pending {n,m} pairs for the combination engine; contents are never reset,
// only the stack pointer is.
module comb_pair_stack #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [W-1:0]    push_data_i,
    output logic [W-1:0]    pop_data_o,
    output logic [SP_W-1:0] sp_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign sp_o    = sp_q;

    assign wr_idx     = IDX_W'(sp_q);
    assign rd_idx     = IDX_W'(sp_q - SP_W'(1));
    assign pop_data_o = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr_i) begin
            sp_d = '0;
        end else if (push_i && !full_o) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/comb_stack_engine.sv
// Iterative C(n,m) evaluator using an explicit pair stack and saturating accumulator.
// Build option COMB_SHORTCUT_EN: also treat m==1 / m==n-1 as leaves worth n.
//
// state   | meaning
// IDLE    | waiting for start; result/err hold last completion
// EVAL    | examine current {n,m}: count a leaf, or push {n-1,m-1} and descend
// POP     | reload {n,m} from the top of the stack
// DONE    | one-cycle done pulse, result/err valid
module comb_stack_engine
    import comb_pkg::*;
#(
    parameter int unsigned N_W   = 6,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [N_W-1:0]   n_in_i,
    input  logic [N_W-1:0]   m_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] result_o,
    output logic [1:0]       err_o
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [N_W-1:0]   m_q, m_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic [1:0]       err_q, err_d;

    logic             stk_clr;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_full;
    logic             stk_empty;
    logic [SP_W-1:0]  stk_sp;
    logic [2*N_W-1:0] stk_rd;

    logic             leaf;
    logic [ACC_W-1:0] leaf_add;
    logic [ACC_W:0]   acc_sum;
    logic             acc_ovf;
    logic [ACC_W-1:0] acc_sat;

`ifdef COMB_SHORTCUT_EN
    logic edge_leaf;
    logic near_leaf;

    assign edge_leaf = (m_q == '0) || (m_q == n_q);
    assign near_leaf = !edge_leaf && ((m_q == N_W'(1)) || (m_q == n_q - N_W'(1)));
    assign leaf      = edge_leaf || near_leaf;
    // C(n,1) == C(n,n-1) == n, so the whole subtree collapses into one add.
    assign leaf_add  = near_leaf ? ACC_W'(n_q) : ACC_W'(1);
`else
    assign leaf      = (m_q == '0) || (m_q == n_q);
    assign leaf_add  = ACC_W'(1);
`endif

    assign acc_sum = {1'b0, acc_q} + {1'b0, leaf_add};
    assign acc_ovf = acc_sum[ACC_W];
    assign acc_sat = acc_ovf ? '1 : acc_sum[ACC_W-1:0];

    comb_pair_stack #(
        .W     (2 * N_W),
        .DEPTH (DEPTH),
        .SP_W  (SP_W)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (stk_clr),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i ({n_q - N_W'(1), m_q - N_W'(1)}),
        .pop_data_o  (stk_rd),
        .sp_o        (stk_sp),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = err_q;
        stk_clr  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = n_in_i;
                    m_d     = m_in_i;
                    acc_d   = '0;
                    err_d   = ERR_OK;
                    stk_clr = 1'b1;
                    if (m_in_i > n_in_i) begin
                        err_d    = ERR_RANGE;
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_EVAL;
                    end
                end
            end

            ST_EVAL: begin
                if (leaf) begin
                    acc_d = acc_sat;
                    if (acc_ovf && (err_q == ERR_OK)) begin
                        err_d = ERR_SAT;
                    end
                    if (stk_empty) begin
                        result_d = acc_sat;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_POP;
                    end
                end else if (stk_full) begin
                    // Overflow outranks an earlier saturation flag.
                    err_d    = ERR_STK;
                    result_d = acc_q;
                    state_d  = ST_DONE;
                end else begin
                    stk_push = 1'b1;
                    n_d      = n_q - N_W'(1);
                    state_d  = ST_EVAL;
                end
            end

            ST_POP: begin
                stk_pop = (stk_sp != '0);
                n_d     = stk_rd[2*N_W-1:N_W];
                m_d     = stk_rd[N_W-1:0];
                state_d = ST_EVAL;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_comb_stack_engine.sv
// Randomised self-checking bench: three engine instances (default, DEPTH=4, ACC_W=8)
// compared every cycle against a cycle-count-level recursion model.
module tb_comb_stack_engine;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  n_in  = '0;
    logic [5:0]  m_in  = '0;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [5:0]  err_v;
    logic [15:0] res0;
    logic [15:0] res1;
    logic [7:0]  res2;

    int checks   = 0;
    int failures = 0;

    int     dep_a  [3] = '{16, 4, 16};
    int     accw_a [3] = '{16, 16, 8};
    bit     e_busy [3];
    bit     e_done [3];
    int     rem    [3];
    longint e_res  [3];
    longint p_res  [3];
    int     e_err  [3];
    int     p_err  [3];

    localparam int LIMIT = 20000;

    always #5 clk = ~clk;

    comb_stack_engine u_def (
        .clk(clk), .rst_n(rst_n), .start_i(start), .n_in_i(n_in), .m_in_i(m_in),
        .busy_o(busy[0]), .done_o(done[0]), .result_o(res0), .err_o(err_v[1:0])
    );

    comb_stack_engine #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .n_in_i(n_in), .m_in_i(m_in),
        .busy_o(busy[1]), .done_o(done[1]), .result_o(res1), .err_o(err_v[3:2])
    );

    comb_stack_engine #(.ACC_W(8)) u_a8 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .n_in_i(n_in), .m_in_i(m_in),
        .busy_o(busy[2]), .done_o(done[2]), .result_o(res2), .err_o(err_v[5:4])
    );

    function automatic logic [63:0] get_res(input int i);
        case (i)
            0:       return {48'd0, res0};
            1:       return {48'd0, res1};
            default: return {56'd0, res2};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Depth-first walk of C(n,m)=C(n-1,m-1)+C(n-1,m): keep descending on (n-1,m),
    // deferring (n-1,m-1). cyc = clock edges from the start edge until DONE.
    function automatic void model(input int n, input int m, input int dep, input int aw,
                                  output longint r, output int e, output int cyc);
        int     sn[$];
        int     sm[$];
        int     cn;
        int     cm;
        longint acc;
        longint mx;
        longint add;
        bit     leafy;
        cn = n; cm = m; acc = 0; e = 0; cyc = 0;
        mx = (longint'(1) << aw) - 1;
        if (m > n) begin
            r = 0; e = 1;
            return;
        end
        while (1) begin
            cyc++;
            leafy = 0;
            add   = 1;
            if (cm == 0 || cm == cn) leafy = 1;
`ifdef COMB_SHORTCUT_EN
            else if (cm == 1 || cm == cn - 1) begin
                leafy = 1;
                add   = cn;
            end
`endif
            if (leafy) begin
                acc += add;
                if (acc > mx) begin
                    acc = mx;
                    if (e == 0) e = 3;
                end
                if (sn.size() == 0) break;
                cyc++;
                cn = sn.pop_back();
                cm = sm.pop_back();
            end else if (sn.size() == dep) begin
                e = 2;
                break;
            end else begin
                sn.push_back(cn - 1);
                sm.push_back(cm - 1);
                cn--;
            end
        end
        r = acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int c;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                e_busy[i] = 0; e_done[i] = 0; rem[i] = 0; e_res[i] = 0; e_err[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (e_done[i]) begin
                    e_done[i] = 0;
                    e_busy[i] = 0;
                end else if (e_busy[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        e_done[i] = 1; e_res[i] = p_res[i]; e_err[i] = p_err[i];
                    end
                end else if (start) begin
                    model(int'(n_in), int'(m_in), dep_a[i], accw_a[i], p_res[i], p_err[i], c);
                    e_busy[i] = 1;
                    if (c == 0) begin
                        e_done[i] = 1; e_res[i] = p_res[i]; e_err[i] = p_err[i];
                    end else begin
                        rem[i] = c;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[%0d]", i), busy[i], e_busy[i]);
                chk($sformatf("done[%0d]", i), done[i], e_done[i]);
                if (e_done[i]) begin
                    chk($sformatf("result[%0d]", i), get_res(i), e_res[i]);
                    chk($sformatf("err[%0d]", i), err_v[2*i +: 2], e_err[i]);
                end else if (!e_busy[i]) begin
                    chk($sformatf("result_hold[%0d]", i), get_res(i), e_res[i]);
                end
            end
        end
    end

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out after %0d cycles", nm, LIMIT);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((e_busy[0] || e_busy[1] || e_busy[2]) && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (k >= LIMIT) timeout("wait_idle");
    endtask

    task automatic launch(input int n, input int m);
        wait_idle();
        n_in  = 6'(n);
        m_in  = 6'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int i, output int k);
        k = 0;
        while (done[i] !== 1'b1 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (k >= LIMIT) timeout($sformatf("wait_done[%0d]", i));
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_busy[%0d]", tag, i), busy[i], 0);
            chk($sformatf("%s_done[%0d]", tag, i), done[i], 0);
            chk($sformatf("%s_result[%0d]", tag, i), get_res(i), 0);
            chk($sformatf("%s_err[%0d]", tag, i), err_v[2*i +: 2], 0);
        end
    endtask

    initial begin
        longint r;
        int     e;
        int     c;
        int     k;
        int     n;
        int     m;
        int     t;

        model(5, 2, 16, 16, r, e, c);
        chk("model_5_2_res", r, 10);
        chk("model_5_2_err", e, 0);
`ifndef COMB_SHORTCUT_EN
        chk("model_5_2_cyc", c, 28);
`endif
        model(3, 5, 16, 16, r, e, c);
        chk("model_3_5_err", e, 1);
        model(12, 6, 16, 8, r, e, c);
        chk("model_12_6_sat_res", r, 255);
        chk("model_12_6_sat_err", e, 3);
`ifndef COMB_SHORTCUT_EN
        model(10, 5, 4, 16, r, e, c);
        chk("model_10_5_d4_err", e, 2);
`endif

        repeat (3) @(negedge clk);
        check_reset_values("por");

        // Release and request in the same cycle: the first IDLE edge must take it.
        rst_n = 1'b1;
        n_in  = 6'd5;
        m_in  = 6'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, k);
`ifndef COMB_SHORTCUT_EN
        chk("lat_5_2", k, 28);
`endif
        chk("res_5_2", res0, 10);
        chk("err_5_2", err_v[1:0], 0);

        launch(4, 4);
        wait_done(0, k);
        chk("lat_4_4", k, 1);
        chk("res_4_4", res0, 1);

        launch(3, 5);
        wait_done(0, k);
        chk("lat_3_5", k, 0);
        chk("res_3_5", res0, 0);
        chk("err_3_5", err_v[1:0], 1);

        launch(10, 5);
        wait_done(1, k);
`ifndef COMB_SHORTCUT_EN
        chk("err_10_5_d4", err_v[3:2], 2);
`endif
        @(negedge clk);
        chk("busy_after_done_d4", busy[1], 0);
        chk("done_pulse_d4", done[1], 0);

        launch(12, 6);
        wait_done(2, k);
        chk("res_12_6_a8", res2, 255);
        chk("err_12_6_a8", err_v[5:4], 3);

        launch(8, 4);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        launch(6, 3);
        wait_done(0, k);
        chk("res_6_3", res0, 20);
`ifdef COMB_SHORTCUT_EN
        chk("lat_6_3_short", (k < 58), 1);
`else
        chk("lat_6_3", k, 58);
`endif

        repeat (25) begin
            n = $urandom_range(0, 11);
            m = $urandom_range(0, n + 1);
            launch(n, m);
            t = 0;
            while ((e_busy[0] || e_busy[1] || e_busy[2]) && t < LIMIT) begin
                if (t < 30) begin
                    n_in  = 6'($urandom_range(0, 11));
                    m_in  = 6'($urandom_range(0, 12));
                    start = ($urandom_range(0, 3) == 0);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                t++;
            end
            start = 1'b0;
            if (t >= LIMIT) timeout("random_txn");
        end

        wait_idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
